// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - write-back queue in front of a register-file write port
// FIFO of pending {dest,data} results drained one per cycle, with youngest-first forwarding lookup.
module regfile_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    input  logic [2:0]  inDest,
    input  logic [15:0] inDat,
    output logic        inReady,
    input  logic        wrtHold,
    output logic        regWrt,
    output logic [2:0]  wDest,
    output logic [15:0] wDat,
    input  logic [2:0]  qDest,
    output logic        qHit,
    output logic [15:0] qDat,
    output logic [3:0]  count
);

    localparam int PW = $clog2(DEPTH);

    logic [2:0]    r_dest [DEPTH];
    logic [15:0]   r_dat  [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [3:0]    r_count;
    logic          r_wrt;
    logic [2:0]    r_wdest;
    logic [15:0]   r_wdat;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_qhit;
    logic [15:0]   w_qdat;

    // No pass-through when full: readiness depends only on the registered count.
    assign w_full  = (r_count == 4'(DEPTH));
    assign inReady = reset && !w_full;
    assign w_push  = inValid && inReady && (inDest != 3'd0);
    assign w_pop   = (r_count != 4'd0) && !wrtHold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dest[i] <= 3'd0;
                r_dat[i]  <= 16'd0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 4'd0;
            r_wrt   <= 1'b0;
            r_wdest <= 3'd0;
            r_wdat  <= 16'd0;
        end else begin
            if (w_push) begin
                r_dest[r_wptr] <= inDest;
                r_dat[r_wptr]  <= inDat;
                r_wptr         <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_wdest <= r_dest[r_rptr];
                r_wdat  <= r_dat[r_rptr];
                r_rptr  <= r_rptr + PW'(1);
            end
            r_wrt   <= w_pop;
            r_count <= r_count + {3'd0, w_push} - {3'd0, w_pop};
        end
    end

    // Oldest candidate first so that younger FIFO entries override older matches.
    always_comb begin
        w_qhit = 1'b0;
        w_qdat = 16'd0;
        if (qDest != 3'd0) begin
            if (r_wrt && (r_wdest == qDest)) begin
                w_qhit = 1'b1;
                w_qdat = r_wdat;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((4'(i) < r_count) && (r_dest[r_rptr + PW'(i)] == qDest)) begin
                    w_qhit = 1'b1;
                    w_qdat = r_dat[r_rptr + PW'(i)];
                end
            end
        end
    end

    assign regWrt = r_wrt;
    assign wDest  = r_wdest;
    assign wDat   = r_wdat;
    assign qHit   = w_qhit;
    assign qDat   = w_qdat;
    assign count  = r_count;

endmodule

// File: doc/regfile_wb_queue.md
REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of pending write-back entries; legal values are 2, 4 or 8.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; assertion (0) SHALL clear state immediately, independent of clk.
REQ-004 inValid  input  1  producer presents a write-back result.
REQ-005 inDest  input  3  destination register index of the result.
REQ-006 inDat  input  16  result data.
REQ-007 inReady  output  1  queue can accept a result this cycle.
REQ-008 wrtHold  input  1  when 1, the register-file write port is unavailable; draining is stalled.
REQ-009 regWrt  output  1  register-file write enable; 1 for exactly one cycle per drained entry.
REQ-010 wDest  output  3  register-file write address.
REQ-011 wDat  output  16  register-file write data.
REQ-012 qDest  input  3  forwarding lookup index, driven by a read-port requester.
REQ-013 qHit  output  1  a write to qDest is pending in the queue or on the write port.
REQ-014 qDat  output  16  youngest pending data for qDest; 0 when qHit=0.
REQ-015 count  output  4  number of entries held in the FIFO, excluding the output register.

Function
REQ-016 A transfer SHALL occur at a rising edge where inValid=1 and inReady=1; a transfer with inDest≠0 SHALL append {inDest, inDat} to the FIFO tail.
REQ-017 A transfer with inDest=0 SHALL be accepted and discarded: count unchanged, no regWrt, no effect on qHit.
REQ-018 inReady SHALL equal (count < DEPTH) while reset is deasserted; there is no pass-through when full, even if a pop occurs in the same cycle.
REQ-019 At each rising edge with count>0 and wrtHold=0, the head entry SHALL pop into the wDest/wDat registers and regWrt SHALL be set to 1; otherwise regWrt SHALL be set to 0 and wDest/wDat SHALL hold their values.
REQ-020 Latency: an entry accepted at edge k into an empty FIFO with wrtHold=0 SHALL appear with regWrt=1 in the cycle following edge k+1.
REQ-021 A push and a pop at the same edge SHALL leave count unchanged and preserve FIFO order.
REQ-022 Writes SHALL reach the register file in acceptance order; no entry is merged or reordered, including repeated destinations.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-024 qHit/qDat SHALL be combinational from the current state.
REQ-025 Search precedence, youngest first: FIFO tail toward head, then the output register (only while regWrt=1).
REQ-026 qDest=0 SHALL give qHit=0 and qDat=0.
REQ-027 An entry being pushed in the current cycle SHALL NOT be visible to the lookup until after the edge.
REQ-028 Asserting wrtHold while regWrt=1 SHALL NOT cancel the current write; it SHALL block only the next pop.

Reset
REQ-029 While reset=0: count=0, regWrt=0, wDest=0, wDat=0, inReady=0, qHit=0, qDat=0; all FIFO contents SHALL be invalidated.
REQ-030 Reset asserted mid-operation SHALL discard all pending entries without emitting further regWrt pulses.
REQ-031 The first transfer SHALL be possible at the first rising edge after reset returns to 1.

Verification
REQ-032 After reset, push (1,0x0001) through (7,0x0007) back-to-back with wrtHold=0 -> regWrt pulses writing 1..7 with matching data, in order, with first-write latency per REQ-020.
REQ-033 With wrtHold=1, push five entries (DEPTH=4) -> inReady drops after the fourth transfer and count=4; release wrtHold -> four writes, then inReady=1.
REQ-034 Push (3,0x0030), then (3,0x0033) with wrtHold=1, qDest=3 -> qHit=1, qDat=0x0033; drain the queue -> qHit=0 after the last regWrt cycle.
REQ-035 Push (0,0xFFFF) -> inReady honored, count stays 0, no regWrt, and qHit=0 for qDest=0.
REQ-036 Assert reset with count=3 and regWrt=1 -> all outputs take their REQ-029 values asynchronously; after release, no stale writes are emitted.
REQ-037 Run a random push/hold stream for 1000 cycles against a reference model -> write sequence, count and lookup match every cycle, including pointer wrap.
